// File: rtl/io_bank_pkg.sv
// Shared types and constants for the general-purpose output pad bank:
// per-pad mode encoding, load FSM states and configuration bits per pad.
package io_bank_pkg;

   localparam int CFG_BITS_PER_PAD = 2;

   typedef enum logic [1:0] {
      GPOUT_DISABLED = 2'b00,
      GPOUT_BYPASS   = 2'b01,
      GPOUT_REG      = 2'b10,
      GPOUT_REG_INV  = 2'b11
   } gpout_mode_t;

   typedef enum logic [1:0] {
      ST_UNCFG   = 2'b00,
      ST_LOADING = 2'b01,
      ST_ACTIVE  = 2'b10,
      ST_ERROR   = 2'b11
   } cfg_state_t;

endpackage

// File: rtl/logical_tile_io_output_bank_gpout_pad_slice.sv
// One output pad: mode decode, capture flops and output mux.
// Optional macro GPOUT_OE_REG_EN registers OE alongside data in REG/REG_INV modes.
module gpout_pad_slice
   import io_bank_pkg::*;
#(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_active,
   input  logic [1:0] i_mode,
   input  logic       i_data,
   input  logic       i_oe,
   output logic       o_pad,
   output logic       o_oe
);

   gpout_mode_t w_mode;
   logic        r_out_q;
   logic        w_reg_oe;

   assign w_mode = gpout_mode_t'(i_mode);

   // Outside ACTIVE the flop is forced to RESET_VALUE, so the first active cycle shows it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_q <= RESET_VALUE;
      end else if (i_active) begin
         r_out_q <= (w_mode == GPOUT_REG_INV) ? ~i_data : i_data;
      end else begin
         r_out_q <= RESET_VALUE;
      end
   end

`ifdef GPOUT_OE_REG_EN
   logic r_oe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oe_q <= 1'b0;
      end else if (i_active) begin
         r_oe_q <= i_oe;
      end else begin
         r_oe_q <= 1'b0;
      end
   end

   assign w_reg_oe = r_oe_q;
`else
   assign w_reg_oe = i_oe;
`endif

   always_comb begin
      o_pad = RESET_VALUE;
      o_oe  = 1'b0;
      if (i_active) begin
         case (w_mode)
            GPOUT_BYPASS: begin
               o_pad = i_data;
               o_oe  = i_oe;
            end
            GPOUT_REG, GPOUT_REG_INV: begin
               o_pad = r_out_q;
               o_oe  = w_reg_oe;
            end
            default: begin
               o_pad = RESET_VALUE;
               o_oe  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/logical_tile_io_output_bank.sv
// Multi-pad general-purpose output bank: configuration chain, bit counter,
// load FSM and NUM_PADS pad slices. Optional macro: GPOUT_OE_REG_EN.
module logical_tile_io_output_bank
   import io_bank_pkg::*;
#(
   parameter int   NUM_PADS    = 8,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_en,
   input  logic                ccff_head,
   output logic                ccff_tail,
   input  logic [NUM_PADS-1:0] iopad_outpad,
   input  logic [NUM_PADS-1:0] iopad_oe,
   output logic [NUM_PADS-1:0] gfpga_pad_GPOUT_PAD,
   output logic [NUM_PADS-1:0] gfpga_pad_GPOUT_OE,
   output logic                cfg_done,
   output logic                cfg_error
);

   localparam int CHAIN_LEN = CFG_BITS_PER_PAD * NUM_PADS;
   localparam int CW        = $clog2(CHAIN_LEN + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0] r_cfg_sr;
   logic [CW-1:0]        r_cnt;
   cfg_state_t           r_state;
   cfg_state_t           w_state_nxt;
   logic                 w_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_sr <= '0;
      end else if (cfg_en) begin
         r_cfg_sr <= {r_cfg_sr[CHAIN_LEN-2:0], ccff_head};
      end
   end

   assign ccff_tail = r_cfg_sr[CHAIN_LEN-1];

   // Counter restarts at 1 on the first cfg_en cycle of every load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (cfg_en) begin
         if (r_state != ST_LOADING) begin
            r_cnt <= CW'(1);
         end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_UNCFG;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (cfg_en) begin
         w_state_nxt = ST_LOADING;
      end else if (r_state == ST_LOADING) begin
         w_state_nxt = (r_cnt == CNT_FULL) ? ST_ACTIVE : ST_ERROR;
      end
   end

   // cfg_en gates w_active directly so pads fall safe on the first reload cycle.
   always_comb begin
      cfg_done  = (r_state == ST_ACTIVE);
      cfg_error = (r_state == ST_ERROR);
      w_active  = (r_state == ST_ACTIVE) && !cfg_en;
   end

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
      gpout_pad_slice #(
         .RESET_VALUE(RESET_VALUE)
      ) u_slice (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_active (w_active),
         .i_mode   (r_cfg_sr[CFG_BITS_PER_PAD*g +: CFG_BITS_PER_PAD]),
         .i_data   (iopad_outpad[g]),
         .i_oe     (iopad_oe[g]),
         .o_pad    (gfpga_pad_GPOUT_PAD[g]),
         .o_oe     (gfpga_pad_GPOUT_OE[g])
      );
   end

endmodule

// File: tb/tb_logical_tile_io_output_bank.sv
// Directed bench for the output pad bank with NUM_PADS = 4 (8-bit chain).
module tb_logical_tile_io_output_bank;

   logic       clk;
   logic       rst_n;
   logic       cfg_en;
   logic       ccff_head;
   logic       ccff_tail;
   logic [3:0] iopad_outpad;
   logic [3:0] iopad_oe;
   logic [3:0] pad;
   logic [3:0] oe;
   logic       cfg_done;
   logic       cfg_error;

   int checks   = 0;
   int failures = 0;

   logic [0:0] exp_q[$];

   typedef struct {
      logic [3:0] outpad;
      logic [3:0] oe_in;
      logic [3:0] exp_pad;
      logic [3:0] exp_oe;
   } vec_t;

   vec_t tbl[7];

   logical_tile_io_output_bank #(
      .NUM_PADS(4),
      .RESET_VALUE(1'b0)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cfg_en              (cfg_en),
      .ccff_head           (ccff_head),
      .ccff_tail           (ccff_tail),
      .iopad_outpad        (iopad_outpad),
      .iopad_oe            (iopad_oe),
      .gfpga_pad_GPOUT_PAD (pad),
      .gfpga_pad_GPOUT_OE  (oe),
      .cfg_done            (cfg_done),
      .cfg_error           (cfg_error)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Shifts n bits of pat MSB-first, then one cycle with cfg_en low.
   task automatic load(input logic [15:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         cfg_en    = 1'b1;
         ccff_head = pat[n-1-i];
         #1;
         chk("load_safe_pad", pad, 4'b0000);
         chk("load_safe_oe", oe, 4'b0000);
         step();
      end
      cfg_en    = 1'b0;
      ccff_head = 1'b0;
      step();
   endtask

   initial begin
      logic       b;
      logic [0:0] e;
      logic [3:0] first_oe;
      logic [3:0] oe_late;
      logic [3:0] oe_mix;

`ifdef GPOUT_OE_REG_EN
      first_oe = 4'b0001;
      oe_late  = 4'b0000;
      oe_mix   = 4'b0011;
`else
      first_oe = 4'b0111;
      oe_late  = 4'b0010;
      oe_mix   = 4'b0001;
`endif
      // pad0 BYPASS, pad1 REG, pad2 REG_INV, pad3 DISABLED; OE inputs held at 0111
      tbl[0] = '{4'b1111, 4'b0111, 4'b0001, first_oe};
      tbl[1] = '{4'b0000, 4'b0111, 4'b0010, 4'b0111};
      tbl[2] = '{4'b0110, 4'b0111, 4'b0100, 4'b0111};
      tbl[3] = '{4'b1001, 4'b0111, 4'b0011, 4'b0111};
      tbl[4] = '{4'b0100, 4'b0111, 4'b0100, 4'b0111};
      tbl[5] = '{4'b0011, 4'b0111, 4'b0001, 4'b0111};
      tbl[6] = '{4'b1010, 4'b0111, 4'b0110, 4'b0111};

      rst_n        = 1'b0;
      cfg_en       = 1'b0;
      ccff_head    = 1'b0;
      iopad_outpad = 4'b1111;
      iopad_oe     = 4'b1111;
      #2;
      chk("rst_pad", pad, 4'b0000);
      chk("rst_oe", oe, 4'b0000);
      chk("rst_done", 4'(cfg_done), 4'd0);
      chk("rst_err", 4'(cfg_error), 4'd0);
      chk("rst_tail", 4'(ccff_tail), 4'd0);
      #10;
      rst_n = 1'b1;
      step();

      // chain pass-through: tail repeats head 8 shifts later
      for (int i = 0; i < 7; i++) exp_q.push_back(1'b0);
      for (int i = 0; i < 16; i++) begin
         b         = 1'($urandom_range(0, 1));
         cfg_en    = 1'b1;
         ccff_head = b;
         exp_q.push_back(b);
         step();
         e = exp_q.pop_front();
         chk("chain_tail", 4'(ccff_tail), 4'(e));
      end
      cfg_en = 1'b0;
      step();
      chk("chain_overlong_err", 4'(cfg_error), 4'd1);

      // short and overlong loads
      load(16'h001C, 7);
      chk("short_err", 4'(cfg_error), 4'd1);
      chk("short_done", 4'(cfg_done), 4'd0);
      chk("short_oe", oe, 4'b0000);
      chk("short_pad", pad, 4'b0000);
      load(16'h00E5, 10);
      chk("long_err", 4'(cfg_error), 4'd1);
      chk("long_done", 4'(cfg_done), 4'd0);
      chk("long_oe", oe, 4'b0000);

      // good load then the vector table
      load(16'h0039, 8);
      chk("good_done", 4'(cfg_done), 4'd1);
      chk("good_err", 4'(cfg_error), 4'd0);
      for (int r = 0; r < 7; r++) begin
         iopad_outpad = tbl[r].outpad;
         iopad_oe     = tbl[r].oe_in;
         #1;
         chk($sformatf("vec%0d_pad", r), pad, tbl[r].exp_pad);
         chk($sformatf("vec%0d_oe", r), oe, tbl[r].exp_oe);
         step();
      end

      // OE latency on the REG pad
      iopad_oe = 4'b0000;
      step();
      #1;
      chk("oe_all_low", oe, 4'b0000);
      iopad_oe = 4'b0010;
      #1;
      chk("oe_rise_same", oe, oe_late);
      step();
      chk("oe_rise_next", oe, 4'b0010);
      iopad_oe = 4'b0001;
      #1;
      chk("oe_bypass_mix", oe, oe_mix);
      step();

      // reconfigure while a REG pad toggles
      iopad_oe = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         iopad_outpad = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         step();
         chk("toggle_pad1", 4'(pad[1]), (i % 2 == 0) ? 4'd1 : 4'd0);
      end
      load(16'h0039, 8);
      chk("reload_done", 4'(cfg_done), 4'd1);
      iopad_outpad = 4'b0010;
      #1;
      chk("reload_first_pad", pad, 4'b0000);
      step();
      chk("reload_second_pad", pad, 4'b0110);

      // asynchronous reset while active
      load(16'h00B9, 8);
      chk("pre_rst_tail", 4'(ccff_tail), 4'd1);
      iopad_outpad = 4'b1111;
      iopad_oe     = 4'b1111;
      step();
      step();
      chk("pre_rst_pad", pad, 4'b1011);
      chk("pre_rst_oe", oe, 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pad", pad, 4'b0000);
      chk("async_rst_oe", oe, 4'b0000);
      chk("async_rst_done", 4'(cfg_done), 4'd0);
      chk("async_rst_tail", 4'(ccff_tail), 4'd0);
      #3;
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_done", 4'(cfg_done), 4'd0);
      chk("post_rst_pad", pad, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
